// File: rtl/mnist_frame_ctrl.sv
// mnist_frame_ctrl: framed-protocol controller between uart_rx, the conv
// accelerator, uart_tx and the 595 display. A sync byte opens a frame, exactly
// IMG_W*IMG_H pixels are forwarded, the accelerator result is range-checked and
// a 3-byte response (header, class, checksum) is sent through a busy-aware TX
// handshake.
//
// Handshakes: rx_valid_i, acc_valid_i, pix_valid_o, tx_start_o and acc_flush_o
// are single-cycle strobes with no back-pressure. The only flow control is
// tx_busy_i. A byte is launched only while tx_busy_i is low. tx_data_o then holds
// its value until uart_tx drops tx_busy_i again.
module mnist_frame_ctrl #(
   parameter int          IMG_W       = 28,
   parameter int          IMG_H       = 28,
   parameter int          RESULT_W    = 32,
   parameter int          NUM_CLASSES = 10,
   parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
   parameter logic [7:0]  RSP_HDR     = 8'h55,
   parameter int          TIMEOUT_CYC = 20000
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [7:0]          rx_byte_i,
   input  logic                rx_valid_i,
   output logic [7:0]          pix_data_o,
   output logic                pix_valid_o,
   output logic                acc_flush_o,
   input  logic [RESULT_W-1:0] acc_result_i,
   input  logic                acc_valid_i,
   output logic [7:0]          tx_data_o,
   output logic                tx_start_o,
   input  logic                tx_busy_i,
   output logic [3:0]          disp_num_o,
   output logic                disp_valid_o,
   output logic                err_flag_o,
   output logic [1:0]          err_code_o,
   output logic [15:0]         frame_cnt_o,
   output logic [2:0]          state_o
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int PCW  = $clog2(NPIX + 1);
   localparam int TCW  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RECV      = 3'd1,
      S_WAIT_RES  = 3'd2,
      S_SEND      = 3'd3,
      S_SEND_WAIT = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
   logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [1:0]     idx_q, idx_d;
   logic           first_q, first_d;
   logic [7:0]     cls_byte_q, cls_byte_d;
   logic [7:0]     pix_data_q, pix_data_d;
   logic           pix_valid_q, pix_valid_d;
   logic           flush_q, flush_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           tx_start_q, tx_start_d;
   logic [3:0]     disp_num_q, disp_num_d;
   logic           disp_valid_q, disp_valid_d;
   logic           err_flag_q, err_flag_d;
   logic [1:0]     err_code_q, err_code_d;
   logic [15:0]    frame_cnt_q, frame_cnt_d;
   logic [7:0]     pkt_byte;

   // Qualified events; a byte arriving on the terminal timeout cycle wins.
   logic sync_hit, pix_take, last_pix, tmo_hit, res_take, res_ok, send_go, send_done;
   assign sync_hit  = (state_q == S_IDLE) && rx_valid_i && (rx_byte_i == SYNC_BYTE);
   assign pix_take  = (state_q == S_RECV) && rx_valid_i;
   assign last_pix  = pix_take && (pix_cnt_q == PCW'(NPIX - 1));
   assign tmo_hit   = (state_q == S_RECV) && !rx_valid_i && (tmo_cnt_q == TCW'(TIMEOUT_CYC - 1));
   assign res_take  = (state_q == S_WAIT_RES) && acc_valid_i;
   assign res_ok    = acc_result_i < RESULT_W'(NUM_CLASSES);
   assign send_go   = (state_q == S_SEND) && !tx_busy_i;
   // The launch cycle is skipped because tx_busy_i only rises after it.
   assign send_done = (state_q == S_SEND_WAIT) && !first_q && !tx_busy_i;

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (sync_hit) state_d = S_RECV;
         S_RECV:      if (last_pix) state_d = S_WAIT_RES;
                      else if (tmo_hit) state_d = S_IDLE;
         S_WAIT_RES:  if (acc_valid_i) state_d = S_SEND;
         S_SEND:      if (send_go) state_d = S_SEND_WAIT;
         S_SEND_WAIT: if (send_done) state_d = (idx_q == 2'd2) ? S_IDLE : S_SEND;
         default:     state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      pix_cnt_d    = pix_cnt_q;
      tmo_cnt_d    = '0;
      idx_d        = idx_q;
      first_d      = send_go;
      cls_byte_d   = cls_byte_q;
      pix_data_d   = pix_data_q;
      pix_valid_d  = pix_take;
      flush_d      = tmo_hit;
      tx_data_d    = tx_data_q;
      tx_start_d   = send_go;
      disp_num_d   = disp_num_q;
      disp_valid_d = disp_valid_q;
      err_flag_d   = err_flag_q;
      err_code_d   = err_code_q;
      frame_cnt_d  = frame_cnt_q;

      case (idx_q)
         2'd0:    pkt_byte = RSP_HDR;
         2'd1:    pkt_byte = cls_byte_q;
         default: pkt_byte = RSP_HDR ^ cls_byte_q;
      endcase

      if (state_q == S_IDLE) pix_cnt_d = '0;
      if (sync_hit) begin
         err_flag_d = 1'b0;
         err_code_d = 2'b00;
      end
      if (pix_take) begin
         pix_cnt_d  = pix_cnt_q + 1'b1;
         pix_data_d = rx_byte_i;
      end
      if ((state_q == S_RECV) && !rx_valid_i && !tmo_hit) tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_hit) begin
         pix_cnt_d  = '0;
         err_flag_d = 1'b1;
         err_code_d = 2'b01;
      end
      if (res_take) begin
         idx_d = 2'd0;
         if (res_ok) begin
            cls_byte_d   = {4'h0, acc_result_i[3:0]};
            disp_num_d   = acc_result_i[3:0];
            disp_valid_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
         end else begin
            cls_byte_d = 8'hEE;
            err_flag_d = 1'b1;
            err_code_d = 2'b10;
         end
      end
      if (send_go) tx_data_d = pkt_byte;
      if (send_done) idx_d = idx_q + 2'd1;
   end

   // Datapath and output registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pix_cnt_q    <= '0;
         tmo_cnt_q    <= '0;
         idx_q        <= 2'd0;
         first_q      <= 1'b0;
         cls_byte_q   <= 8'h00;
         pix_data_q   <= 8'h00;
         pix_valid_q  <= 1'b0;
         flush_q      <= 1'b0;
         tx_data_q    <= 8'h00;
         tx_start_q   <= 1'b0;
         disp_num_q   <= 4'h0;
         disp_valid_q <= 1'b0;
         err_flag_q   <= 1'b0;
         err_code_q   <= 2'b00;
         frame_cnt_q  <= 16'h0000;
      end else begin
         pix_cnt_q    <= pix_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         idx_q        <= idx_d;
         first_q      <= first_d;
         cls_byte_q   <= cls_byte_d;
         pix_data_q   <= pix_data_d;
         pix_valid_q  <= pix_valid_d;
         flush_q      <= flush_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         disp_num_q   <= disp_num_d;
         disp_valid_q <= disp_valid_d;
         err_flag_q   <= err_flag_d;
         err_code_q   <= err_code_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign pix_data_o   = pix_data_q;
   assign pix_valid_o  = pix_valid_q;
   assign acc_flush_o  = flush_q;
   assign tx_data_o    = tx_data_q;
   assign tx_start_o   = tx_start_q;
   assign disp_num_o   = disp_num_q;
   assign disp_valid_o = disp_valid_q;
   assign err_flag_o   = err_flag_q;
   assign err_code_o   = err_code_q;
   assign frame_cnt_o  = frame_cnt_q;
   assign state_o      = state_q;

endmodule
